cbrt_param: RTL and testbench
=============================

Name: cbrt_param

Overview:
- Parametrised, iterative integer cube-root unit: floor(cbrt(x)) plus remainder for a WIDTH-bit unsigned operand.
- Next generation of the fixed 8-bit cbrt datapath. Adds:
  - generic operand width;
  - a one-cycle done strobe;
  - a remainder output;
  - fully internal arithmetic, with no external adder ports.
- Sits as a start/busy slave under a controlling FSM or bench, same handshake style as the existing cbrt.

Parameters:
- WIDTH, default 8, operand width in bits; legal range 3..32.
- RES_W, default (WIDTH+2)/3, result width and iteration count. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- x_i  in  WIDTH  unsigned operand; sampled on the accepted start edge only.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse on completion.
- result  out  RES_W  floor cube root.
- remainder  out  WIDTH  x - result^3.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE;
  - busy=0, done=0, result=0, remainder=0;
  - internal x/y/b registers cleared.
- Release of rst is synchronous to clk. The first edge after release may accept start.
- States are IDLE, CALC, UPDATE.
- Transitions:
  - IDLE → CALC on a rising edge with start=1. That edge loads xr=x_i, y=0, i=RES_W-1, busy=1, done=0.
  - CALC (1 cycle):
    - y ← 2y;
    - b ← (3·(2y)·(2y+1)+1) << (3i), computed in 2·WIDTH+2 bits with no truncation.
  - UPDATE (1 cycle): if xr ≥ b then xr ← xr−b and y ← y+1.
    - If i=0: go to IDLE; load result←y_new and remainder←xr_new; set busy=0 and done=1.
    - Otherwise: i ← i−1 and return to CALC.
  - done is high for exactly one cycle, the first IDLE cycle, then clears.
- Latency:
  - busy is high for exactly 2·RES_W cycles.
  - WIDTH=8: 6 cycles. WIDTH=16: 12 cycles.
  - Result and done appear at the edge that drops busy.
- result and remainder are held stable from the done edge until the next accepted start.
  - They do not change when an operation starts; they are updated only at completion.
- start while busy=1 is ignored, with no queuing.
- start held high continuously:
  - a new operation is accepted on the edge where done rises, i.e. back-to-back;
  - done and the new busy are both high in that cycle.
- x_i changing during an operation has no effect.
- Boundaries:
  - x=0 → result 0, remainder 0.
  - x=2^WIDTH−1 → no overflow. Comparison is full precision, and remainder always fits in WIDTH bits.
- rst asserted mid-operation aborts immediately to reset values. No done pulse is generated for the aborted operation.

Decomposition:
- Package cbrt_pkg holds:
  - the state enum (IDLE, CALC, UPDATE);
  - function res_width(width) = (width+2)/3;
  - localparam for the intermediate b width (2·WIDTH+2).
- Sub-module cbrt_step (combinational): given y, xr and shift index i, produce b and the ge flag.
  - cbrt_param instantiates it once and registers its outputs across CALC and UPDATE.

Test Plan:
- WIDTH=8, x=27, start for 1 cycle → busy high for 6 cycles; result=3, remainder=0; done single pulse.
- WIDTH=8, sweep x=0..255 → result=floor(cbrt(x)) and remainder=x−result³ against a reference model. Specific checks: 255→6/39, 200→5/75, 8→2/0, 0→0/0.
- WIDTH=8, x=64, pulse start again at cycles 2 and 4 of busy with x_i=125 → ignored; result=4, remainder=0, busy length unchanged at 6.
- WIDTH=8, start held high, x_i=216 then 125 → done pulses coincide with re-acceptance. Results 6/0 then 5/0, with no idle cycles between operations.
- WIDTH=8, x=216, drop rst at cycle 3 of busy → busy, done, result and remainder go to 0 asynchronously, before the next edge. After release, x=27 gives 3/0.
- WIDTH=16, x=65535 → busy for 12 cycles; result=40, remainder=1535. Also x=64000 → 40/0.

Source files
------------

// File: rtl/cbrt_pkg.sv
// Shared types and width helpers for the iterative cube-root unit.
package cbrt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StCalc   = 2'd1;
  localparam state_t StUpdate = 2'd2;

  function automatic int unsigned res_width(input int unsigned width);
    return (width + 2) / 3;
  endfunction

  // b is formed at full precision so the compare never truncates
  function automatic int unsigned b_width(input int unsigned width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/cbrt_param_if.sv
// Start/busy handshake and result bus of the cube-root unit.
interface cbrt_param_if
  import cbrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned RES_W = res_width(WIDTH);

  logic             start;
  logic [WIDTH-1:0] x_i;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
  logic [WIDTH-1:0] remainder;

  modport master (output start, x_i, input busy, done, result, remainder);
  modport slave  (input start, x_i, output busy, done, result, remainder);
endinterface

// File: rtl/cbrt_step.sv
// One digit of the cube-root recurrence: trial subtrahend b and the x >= b decision.
module cbrt_step
  import cbrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RES_W = res_width(WIDTH),
  parameter int unsigned IW    = 1,
  parameter int unsigned BW    = b_width(WIDTH)
) (
  input  logic [RES_W-1:0] y2_i,
  input  logic [WIDTH-1:0] xr_i,
  input  logic [IW-1:0]    i_i,
  output logic [BW-1:0]    b_o,
  output logic             ge_o
);

  logic [BW-1:0] y_ext;
  logic [BW-1:0] core;

  always_comb begin
    y_ext = BW'(y2_i);
    core  = (y_ext * (y_ext + BW'(1))) * BW'(3) + BW'(1);
    b_o   = core << (3 * i_i);
    ge_o  = BW'(xr_i) >= b_o;
  end

endmodule

// File: rtl/cbrt_param.sv
// Iterative floor cube root with remainder, one result bit per CALC/UPDATE pair.
module cbrt_param
  import cbrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  cbrt_param_if.slave  bus
);

  localparam int unsigned RES_W = res_width(WIDTH);
  localparam int unsigned BW    = b_width(WIDTH);
  localparam int unsigned IW    = (RES_W > 1) ? $clog2(RES_W) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [RES_W-1:0] y_q, y_d;
  logic [IW-1:0]    i_q, i_d;
  logic [BW-1:0]    b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [RES_W-1:0] y2;
  logic [BW-1:0]    step_b;
  logic             step_ge;
  logic [WIDTH-1:0] xr_new;
  logic [RES_W-1:0] y_new;
  logic             unused_b_hi;

  // y is already doubled by the time UPDATE needs the compare
  assign y2 = (state_q == StCalc) ? (y_q << 1) : y_q;

  cbrt_step #(
    .WIDTH (WIDTH),
    .RES_W (RES_W),
    .IW    (IW),
    .BW    (BW)
  ) u_step (
    .y2_i (y2),
    .xr_i (xr_q),
    .i_i  (i_q),
    .b_o  (step_b),
    .ge_o (step_ge)
  );

  // When ge holds, b <= xr so its upper bits are zero
  assign unused_b_hi = ^b_q[BW-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    y_d      = y_q;
    i_d      = i_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    xr_new   = step_ge ? (xr_q - b_q[WIDTH-1:0]) : xr_q;
    y_new    = step_ge ? (y_q + RES_W'(1)) : y_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCalc;
          xr_d    = bus.x_i;
          y_d     = '0;
          i_d     = IW'(RES_W - 1);
          busy_d  = 1'b1;
        end
      end
      StCalc: begin
        y_d     = y_q << 1;
        b_d     = step_b;
        state_d = StUpdate;
      end
      StUpdate: begin
        xr_d = xr_new;
        y_d  = y_new;
        if (i_q == '0) begin
          result_d = y_new;
          rem_d    = xr_new;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
          // Held start is accepted on the completion edge for back-to-back operation
          if (bus.start) begin
            state_d = StCalc;
            xr_d    = bus.x_i;
            y_d     = '0;
            i_d     = IW'(RES_W - 1);
            busy_d  = 1'b1;
          end
        end else begin
          i_d     = i_q - IW'(1);
          state_d = StCalc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      xr_q     <= '0;
      y_q      <= '0;
      i_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      xr_q     <= xr_d;
      y_q      <= y_d;
      i_q      <= i_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_cbrt_param.sv
// Self-checking bench for cbrt_param at WIDTH=8 and WIDTH=16.
module tb_cbrt_param;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cbrt_param_if #(.WIDTH(8))  b8 ();
  cbrt_param_if #(.WIDTH(16)) b16 ();

  cbrt_param #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  cbrt_param #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned x;
    int unsigned r;
    int unsigned rem;
  } vec_t;

  function automatic longint ref_root(input longint x);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic op8(input int unsigned x, output int bcyc, output int dcnt);
    @(negedge clk);
    b8.x_i   = 8'(x);
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    bcyc = 0;
    dcnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (b8.busy) bcyc++;
      if (b8.done) dcnt++;
      @(negedge clk);
    end
  endtask

  task automatic op16(input int unsigned x, output int bcyc, output int dcnt);
    @(negedge clk);
    b16.x_i   = 16'(x);
    b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    bcyc = 0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (b16.busy) bcyc++;
      if (b16.done) dcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   bcyc, dcnt, gap, nd;
    int   dn[2], dres[2], drem[2], dbusy[2];
    int unsigned rx;

    checks = 0;
    errors = 0;
    tbl[0] = '{27, 3, 0};
    tbl[1] = '{255, 6, 39};
    tbl[2] = '{200, 5, 75};
    tbl[3] = '{8, 2, 0};
    tbl[4] = '{0, 0, 0};
    tbl[5] = '{64, 4, 0};
    tbl[6] = '{216, 6, 0};
    tbl[7] = '{7, 1, 6};

    rst       = 1'b0;
    b8.start  = 1'b0;
    b8.x_i    = '0;
    b16.start = 1'b0;
    b16.x_i   = '0;
    #12;
    chk("reset busy", b8.busy, 0);
    chk("reset done", b8.done, 0);
    chk("reset result", b8.result, 0);
    chk("reset remainder", b8.remainder, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[j]) begin
      op8(tbl[j].x, bcyc, dcnt);
      chk($sformatf("table busy len x=%0d", tbl[j].x), bcyc, 6);
      chk($sformatf("table done count x=%0d", tbl[j].x), dcnt, 1);
      chk($sformatf("table result x=%0d", tbl[j].x), b8.result, tbl[j].r);
      chk($sformatf("table remainder x=%0d", tbl[j].x), b8.remainder, tbl[j].rem);
    end

    for (int x = 0; x < 256; x++) begin
      op8(x, bcyc, dcnt);
      chk($sformatf("sweep busy x=%0d", x), bcyc, 6);
      chk($sformatf("sweep result x=%0d", x), b8.result, ref_root(x));
      chk($sformatf("sweep remainder x=%0d", x), b8.remainder,
          x - ref_root(x) * ref_root(x) * ref_root(x));
    end

    // Start pulses during busy must be ignored
    @(negedge clk);
    b8.x_i   = 8'd64;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    bcyc = 0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (b8.busy) bcyc++;
      if (b8.done) dcnt++;
      b8.start = (k == 1 || k == 3);
      b8.x_i   = (k == 1 || k == 3) ? 8'd125 : 8'd64;
      @(negedge clk);
    end
    chk("ignored start busy len", bcyc, 6);
    chk("ignored start done count", dcnt, 1);
    chk("ignored start result", b8.result, 4);
    chk("ignored start remainder", b8.remainder, 0);

    // Held start: back-to-back operations, x_i changes mid-flight
    @(negedge clk);
    b8.x_i   = 8'd216;
    b8.start = 1'b1;
    @(negedge clk);
    gap = 0;
    nd  = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n <= 12 && !b8.busy) gap++;
      if (b8.done) begin
        if (nd < 2) begin
          dn[nd]    = n;
          dres[nd]  = int'(b8.result);
          drem[nd]  = int'(b8.remainder);
          dbusy[nd] = int'(b8.busy);
        end
        nd++;
      end
      if (n == 3) b8.x_i = 8'd125;
      if (n == 7) b8.start = 1'b0;
      @(negedge clk);
    end
    chk("b2b done count", nd, 2);
    chk("b2b busy gaps", gap, 0);
    if (nd >= 2) begin
      chk("b2b first done cycle", dn[0], 7);
      chk("b2b first done with busy", dbusy[0], 1);
      chk("b2b first result", dres[0], 6);
      chk("b2b first remainder", drem[0], 0);
      chk("b2b second done cycle", dn[1], 13);
      chk("b2b second busy", dbusy[1], 0);
      chk("b2b second result", dres[1], 5);
      chk("b2b second remainder", drem[1], 0);
    end

    // Asynchronous abort mid-operation
    @(negedge clk);
    b8.x_i   = 8'd216;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy before reset", b8.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort busy", b8.busy, 0);
    chk("abort done", b8.done, 0);
    chk("abort result", b8.result, 0);
    chk("abort remainder", b8.remainder, 0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (b8.done || b8.busy) dcnt++;
      @(negedge clk);
    end
    chk("abort no later activity", dcnt, 0);
    op8(27, bcyc, dcnt);
    chk("post abort result", b8.result, 3);
    chk("post abort remainder", b8.remainder, 0);
    chk("post abort busy len", bcyc, 6);

    op16(65535, bcyc, dcnt);
    chk("w16 max busy len", bcyc, 12);
    chk("w16 max done count", dcnt, 1);
    chk("w16 max result", b16.result, 40);
    chk("w16 max remainder", b16.remainder, 1535);
    op16(64000, bcyc, dcnt);
    chk("w16 64000 result", b16.result, 40);
    chk("w16 64000 remainder", b16.remainder, 0);

    for (int t = 0; t < 40; t++) begin
      rx = $urandom_range(0, 65535);
      op16(rx, bcyc, dcnt);
      chk($sformatf("w16 rand busy x=%0d", rx), bcyc, 12);
      chk($sformatf("w16 rand result x=%0d", rx), b16.result, ref_root(rx));
      chk($sformatf("w16 rand remainder x=%0d", rx), b16.remainder,
          rx - ref_root(rx) * ref_root(rx) * ref_root(rx));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
